// File: rtl/register_bank_port_ctrl_if.sv
// Bus between the pipeline-side port controller and its environment
// (decode/writeback stages and register_bank).
//   master : the controller. It drives WB_READY, OP_*, RA/RB and WC/WPC/W_RB,
//            and receives the writeback, read-request and bank read-data inputs.
//   slave  : the environment, with every direction reversed.
// Parameters: AW = register address width, DW = data width.
interface register_bank_port_ctrl_if #(
    parameter int AW = 4,
    parameter int DW = 32
);
    logic          WB_VALID;
    logic          WB_READY;
    logic [AW-1:0] WB_DEST;
    logic [DW-1:0] WB_DATA;
    logic          WR_HOLD;
    logic          RD_REQ;
    logic [AW-1:0] RD_A;
    logic [AW-1:0] RD_B;
    logic          OP_VALID;
    logic [DW-1:0] OP_A;
    logic [DW-1:0] OP_B;
    logic [AW-1:0] RA;
    logic [AW-1:0] RB;
    logic [DW-1:0] PRA;
    logic [DW-1:0] PRB;
    logic [AW-1:0] WC;
    logic [DW-1:0] WPC;
    logic          W_RB;

    modport master (
        input  WB_VALID, WB_DEST, WB_DATA, WR_HOLD,
        input  RD_REQ, RD_A, RD_B, PRA, PRB,
        output WB_READY, OP_VALID, OP_A, OP_B, RA, RB, WC, WPC, W_RB
    );

    modport slave (
        output WB_VALID, WB_DEST, WB_DATA, WR_HOLD,
        output RD_REQ, RD_A, RD_B, PRA, PRB,
        input  WB_READY, OP_VALID, OP_A, OP_B, RA, RB, WC, WPC, W_RB
    );
endinterface

// File: rtl/register_bank_port_ctrl.sv
// Pipeline-side master for register_bank.
// Writeback requests are queued in a DEPTH-entry FIFO and drained into the
// bank one per cycle (WC/WPC/W_RB) unless WR_HOLD is set. Operand reads are
// registered with one cycle of latency; values still in flight (the request
// being accepted this cycle or any queued entry) are bypassed so the newest
// write to a register always wins over the bank contents.
// Ports:
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   bus (master) : WB_* writeback handshake, WR_HOLD, RD_* read request,
//                  OP_* registered operands, RA/RB + PRA/PRB bank read port,
//                  WC/WPC/W_RB bank write port
module register_bank_port_ctrl #(
    parameter int DEPTH = 4,
    parameter int AW    = 4,
    parameter int DW    = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    register_bank_port_ctrl_if.master bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [AW-1:0] dest_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          wb_ready;
    logic          accept;
    logic          drain;
    logic          fifo_nonempty;

    logic [PW-1:0] idx;
    logic [DW-1:0] res_a;
    logic [DW-1:0] res_b;

    logic          op_valid;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;

    // Readiness depends on the registered count only: a full FIFO refuses
    // a request even in a cycle where it also drains.
    assign wb_ready      = (count < CW'(DEPTH));
    assign accept        = bus.WB_VALID && wb_ready;
    assign fifo_nonempty = (count != '0);
    assign drain         = fifo_nonempty && !bus.WR_HOLD;

    // Pointers are PW bits wide and DEPTH is a power of two, so they wrap
    // modulo DEPTH without explicit compare.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + PW'(1);
            if (drain)  rd_ptr <= rd_ptr + PW'(1);
            case ({accept, drain})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset: validity is tracked by count alone.
    always_ff @(posedge clock) begin
        if (accept) begin
            dest_q[wr_ptr] <= bus.WB_DEST;
            data_q[wr_ptr] <= bus.WB_DATA;
        end
    end

    // Operand resolution, newest wins: scan valid entries oldest to youngest
    // so younger matches overwrite older ones, then let the request accepted
    // this cycle override everything. The head being drained on this edge
    // is still in the scan because the bank only commits it at the edge.
    always_comb begin
        res_a = bus.PRA;
        res_b = bus.PRB;
        idx   = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if (CW'(k) < count) begin
                if (dest_q[idx] == bus.RD_A) res_a = data_q[idx];
                if (dest_q[idx] == bus.RD_B) res_b = data_q[idx];
            end
        end
        if (accept && (bus.WB_DEST == bus.RD_A)) res_a = bus.WB_DATA;
        if (accept && (bus.WB_DEST == bus.RD_B)) res_b = bus.WB_DATA;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_valid <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
        end else if (bus.RD_REQ) begin
            op_valid <= 1'b1;
            op_a     <= res_a;
            op_b     <= res_b;
        end else begin
            op_valid <= 1'b0;
        end
    end

    assign bus.WB_READY = wb_ready;
    assign bus.OP_VALID = op_valid;
    assign bus.OP_A     = op_a;
    assign bus.OP_B     = op_b;
    assign bus.RA       = bus.RD_A;
    assign bus.RB       = bus.RD_B;
    assign bus.W_RB     = drain;
    assign bus.WC       = fifo_nonempty ? dest_q[rd_ptr] : '0;
    assign bus.WPC      = fifo_nonempty ? data_q[rd_ptr] : '0;
endmodule

// File: doc/register_bank_port_ctrl.md
Name: register_bank_port_ctrl

Overview:
- Pipeline-side master for register_bank. It owns the RA/RB read addresses and the WC/WPC/W_RB write port.
- Buffers writeback requests in a DEPTH-entry FIFO and drains them into the bank one per cycle.
- Registers operand reads and bypasses not-yet-committed writes, so decode always sees the newest value.
- Sits between the decode/writeback stages and register_bank.

Parameters:
DEPTH, 4, writeback FIFO entries (power of two, 2..8)
AW, 4, register address width (16 registers)
DW, 32, data width

Ports:
clock  in  1  single system clock, rising edge
reset  in  1  asynchronous, active-high reset
WB_VALID  in  1  writeback request valid
WB_READY  out  1  FIFO can accept a request
WB_DEST  in  AW  destination register
WB_DATA  in  DW  data to write
WR_HOLD  in  1  bank write port busy; suppresses draining
RD_REQ  in  1  operand read request
RD_A  in  AW  operand A register
RD_B  in  AW  operand B register
OP_VALID  out  1  OP_A/OP_B hold a registered result
OP_A  out  DW  operand A value
OP_B  out  DW  operand B value
RA  out  AW  bank read address A (combinational = RD_A)
RB  out  AW  bank read address B (combinational = RD_B)
PRA  in  DW  bank read data A (combinational from RA)
PRB  in  DW  bank read data B (combinational from RB)
WC  out  AW  bank write address (= FIFO head dest)
WPC  out  DW  bank write data (= FIFO head data)
W_RB  out  1  bank write enable

Behaviour:
- Bank contract: register_bank commits WPC into register WC on a rising edge when W_RB=1. Reads are combinational. No hardwired zero register; register 0 is writable.
- Reset (async, any time, including mid-drain or mid-read):
  - FIFO count=0, pointers=0, all pending entries discarded.
  - OP_VALID=0, OP_A=0, OP_B=0.
  - W_RB=0, WC=0, WPC=0, WB_READY=1.
- Write path:
  - Accept when WB_VALID & WB_READY. WB_READY = (count < DEPTH), a function of registered count only; a full FIFO does not accept even if it drains that cycle.
  - Drain when count>0 and WR_HOLD=0. W_RB = drain, combinational from state and WR_HOLD.
  - When count=0: WC=0, WPC=0.
  - Accept and drain in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
  - Writes commit in acceptance order. Duplicate destinations are allowed; the later one wins in the bank.
- Read path:
  - On the edge where RD_REQ=1: OP_VALID<=1 and OP_A<=resolve(RD_A), OP_B<=resolve(RD_B). Latency is one cycle.
  - RD_REQ=0: OP_VALID<=0, OP_A/OP_B hold their last values.
- resolve(r), newest wins:
  1. WB_DATA if a request with WB_DEST=r is accepted this cycle.
  2. Else the youngest FIFO entry with dest=r, including the head being drained this edge.
  3. Else PRA/PRB.
- A refused write (WB_READY=0) is never bypassed.
- RD_A=RD_B is legal; both operands receive the same resolved value.
- No combinational path from WB_* to OP_*; OP_* are registers.

Test Plan:
- Reset, then write r0..r15 with value=index, WR_HOLD=0. Then read pairs (0,1),(2,3)…(14,15) → OP_A=even index, OP_B=odd index, OP_VALID=1 one cycle after each RD_REQ.
- WR_HOLD=1, push 4 writes (r3=0xA,r5=0xB,r3=0xC,r7=0xD) → WB_READY=0 after 4th. 5th request refused and not bypassed. RD_A=3,RD_B=5 → 0xC,0xB.
- Release WR_HOLD → W_RB=1 for exactly 4 consecutive cycles with WC=3,5,3,7 in order. Bank r3 ends at 0xC.
- Same-cycle write r9=0x55AA with RD_A=9, bank r9=0x1 → next cycle OP_A=0x55AA. Bank r9=0x55AA after the drain.
- Full FIFO and a drain in the same cycle with WB_VALID=1 → request not accepted that cycle, accepted the next. Count sequence 4→3→4.
- Assert reset with 3 entries pending and OP_VALID=1 → W_RB, OP_VALID, OP_A, OP_B =0 immediately. No pending write reaches the bank after release.
